// File: rtl/pwm_pkg.sv
// Shared constants and types for the multi-channel PS/2-controlled PWM block.
package pwm_pkg;

  // PS/2 prefix bytes
  localparam logic [7:0] KEY_BRK = 8'hF0;
  localparam logic [7:0] KEY_EXT = 8'hE0;

  // Channel select keys (1, 2, 3, 4 on the number row)
  localparam logic [7:0] KEY_CH0 = 8'h16;
  localparam logic [7:0] KEY_CH1 = 8'h1E;
  localparam logic [7:0] KEY_CH2 = 8'h26;
  localparam logic [7:0] KEY_CH3 = 8'h25;

  // Duty level keys
  localparam logic [7:0] KEY_L41 = 8'h2B;
  localparam logic [7:0] KEY_L51 = 8'h15;
  localparam logic [7:0] KEY_L61 = 8'h33;
  localparam logic [7:0] KEY_L81 = 8'h22;
  localparam logic [7:0] KEY_L0  = 8'h45;

  // Duty levels, in counter states
  localparam logic [7:0] LVL_41 = 8'd41;
  localparam logic [7:0] LVL_51 = 8'd51;
  localparam logic [7:0] LVL_61 = 8'd61;
  localparam logic [7:0] LVL_81 = 8'd81;
  localparam logic [7:0] LVL_0  = 8'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BRK  = 2'd1,
    EXT  = 2'd2
  } dec_state_t;

endpackage

// File: rtl/pwm_multi_ramp_if.sv
// Scancode byte stream from the PS/2 receiver.
interface pwm_multi_ramp_if;
  logic [7:0] scancode;
  logic       code_valid;

  modport master (output scancode, output code_valid);
  modport slave  (input  scancode, input  code_valid);
endinterface

// File: rtl/pwm_channel_ramp.sv
// One PWM channel: target/active duty registers, slew-limited ramp applied at
// period boundaries, and edge/center-aligned compare with a registered output.
module pwm_channel_ramp #(
  parameter int CNT_W  = 10,
  parameter int PERIOD = 800,
  parameter int STEP   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             boundary,
  input  logic             mode,
  input  logic [CNT_W-1:0] cnt,
  input  logic             wr,
  input  logic [7:0]       lvl,
  output logic             pwm,
  output logic             busy
);

  localparam int DW = CNT_W + 1;
  localparam logic [DW-1:0]   PER      = DW'(PERIOD);
  localparam logic [DW-1:0]   STP      = DW'(STEP);
  localparam logic [DW+7:0]   PER_WIDE = (DW+8)'(PERIOD);

  logic [DW-1:0] target;
  logic [DW-1:0] active;
  logic [DW-1:0] diff;
  logic [DW-1:0] delta;
  logic [DW-1:0] clamped;
  logic [DW-1:0] lo;
  logic [DW-1:0] hi;
  logic [DW-1:0] cnt_ext;
  logic [DW+7:0] lvl_wide;
  logic          pwm_nxt;

  assign lvl_wide = {{DW{1'b0}}, lvl};
  assign cnt_ext  = {1'b0, cnt};
  assign busy     = (active != target);

  // Clamp the requested level to the period, and size this boundary's ramp step.
  always_comb begin
    clamped = '0;
    diff    = '0;
    delta   = '0;
    if (lvl_wide > PER_WIDE) begin
      clamped = PER;
    end else begin
      clamped = lvl_wide[DW-1:0];
    end
    if (active < target) begin
      diff = target - active;
    end else begin
      diff = active - target;
    end
    if (diff < STP) begin
      delta = diff;
    end else begin
      delta = STP;
    end
  end

  // Target takes a new level whenever the decoder writes this channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target <= '0;
    end else if (wr) begin
      target <= clamped;
    end
  end

  // Active duty moves toward target only at a period boundary, so no runts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= '0;
    end else if (boundary) begin
      if (active < target) begin
        active <= active + delta;
      end else if (active > target) begin
        active <= active - delta;
      end
    end
  end

  // Compare window: edge mode starts at 0, center mode is symmetric in the period.
  always_comb begin
    lo      = (PER - active) >> 1;
    hi      = lo + active;
    pwm_nxt = 1'b0;
    if (mode) begin
      pwm_nxt = (cnt_ext >= lo) && (cnt_ext < hi);
    end else begin
      pwm_nxt = (cnt_ext < active);
    end
  end

  // Registered output keeps the pin free of compare glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm <= 1'b0;
    end else begin
      pwm <= pwm_nxt;
    end
  end

endmodule

// File: rtl/pwm_multi_ramp.sv
// Multi-channel PWM driven by PS/2 scancodes: key decoder, shared prescaler and
// period counter, and one ramping channel per output.
module pwm_multi_ramp
  import pwm_pkg::*;
#(
  parameter int CH     = 4,
  parameter int CNT_W  = 10,
  parameter int PERIOD = 800,
  parameter int PRESC  = 625,
  parameter int STEP   = 1
) (
  input  logic             clkdiv4,
  input  logic             reset,
  pwm_multi_ramp_if.slave  kbd,
  input  logic             center,
  output logic [CH-1:0]    pwm,
  output logic [1:0]       sel,
  output logic             ramping
);

  localparam int PRE_W = (PRESC > 1) ? $clog2(PRESC) : 1;

  logic [PRE_W-1:0] pre;
  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic             boundary;
  logic             mode;
  dec_state_t       state;
  dec_state_t       state_nxt;
  logic [1:0]       sel_nxt;
  logic             wr;
  logic [7:0]       wr_lvl;
  logic [CH-1:0]    busy;

  assign tick     = (pre == PRE_W'(PRESC - 1));
  assign boundary = tick && (cnt == CNT_W'(PERIOD - 1));

  // Prescaler: one counter step every PRESC clocks.
  always_ff @(posedge clkdiv4 or negedge reset) begin
    if (!reset) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + PRE_W'(1);
    end
  end

  // Shared period counter, wrapping after PERIOD states.
  always_ff @(posedge clkdiv4 or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (boundary) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Alignment mode changes only between periods.
  always_ff @(posedge clkdiv4 or negedge reset) begin
    if (!reset) begin
      mode <= 1'b0;
    end else if (boundary) begin
      mode <= center;
    end
  end

  // Decoder next state: break/extended prefixes swallow the following byte.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    wr        = 1'b0;
    wr_lvl    = 8'd0;
    if (kbd.code_valid) begin
      case (state)
        IDLE: begin
          case (kbd.scancode)
            KEY_BRK: state_nxt = BRK;
            KEY_EXT: state_nxt = EXT;
            KEY_CH0: sel_nxt = 2'd0;
            KEY_CH1: if (CH > 1) sel_nxt = 2'd1; else sel_nxt = sel;
            KEY_CH2: if (CH > 2) sel_nxt = 2'd2; else sel_nxt = sel;
            KEY_CH3: if (CH > 3) sel_nxt = 2'd3; else sel_nxt = sel;
            KEY_L41: begin wr = 1'b1; wr_lvl = LVL_41; end
            KEY_L51: begin wr = 1'b1; wr_lvl = LVL_51; end
            KEY_L61: begin wr = 1'b1; wr_lvl = LVL_61; end
            KEY_L81: begin wr = 1'b1; wr_lvl = LVL_81; end
            KEY_L0:  begin wr = 1'b1; wr_lvl = LVL_0;  end
            default: state_nxt = IDLE;
          endcase
        end
        BRK: state_nxt = IDLE;
        EXT: begin
          if (kbd.scancode == KEY_BRK) begin
            state_nxt = BRK;
          end else begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end else begin
      state_nxt = state;
    end
  end

  // Decoder state and channel select registers.
  always_ff @(posedge clkdiv4 or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      sel   <= 2'd0;
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
    end
  end

  genvar i;
  generate
    for (i = 0; i < CH; i++) begin : g_ch
      pwm_channel_ramp #(
        .CNT_W  (CNT_W),
        .PERIOD (PERIOD),
        .STEP   (STEP)
      ) u_ch (
        .clk      (clkdiv4),
        .rst_n    (reset),
        .boundary (boundary),
        .mode     (mode),
        .cnt      (cnt),
        .wr       (wr && (sel == 2'(i))),
        .lvl      (wr_lvl),
        .pwm      (pwm[i]),
        .busy     (busy[i])
      );
    end
  endgenerate

  // Ramp status, registered from the channels' target/active registers.
  always_ff @(posedge clkdiv4 or negedge reset) begin
    if (!reset) begin
      ramping <= 1'b0;
    end else begin
      ramping <= |busy;
    end
  end

endmodule

// File: tb/tb_pwm_multi_ramp.sv
// Scoreboard bench for pwm_multi_ramp: two instances (4ch/PERIOD=100 and
// 1ch/PERIOD=60 with clamping) share one scancode stream; a behavioural model
// queues expected outputs each clock and a monitor compares on the falling edge.
module tb_pwm_multi_ramp;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic center = 1'b0;

  pwm_multi_ramp_if kbd ();

  logic [3:0] pwm0;
  logic [1:0] sel0;
  logic       ramp0;
  logic [0:0] pwm1;
  logic [1:0] sel1;
  logic       ramp1;

  pwm_multi_ramp #(.CH(4), .CNT_W(10), .PERIOD(100), .PRESC(1), .STEP(10)) dut0 (
    .clkdiv4(clk), .reset(rst_n), .kbd(kbd), .center(center),
    .pwm(pwm0), .sel(sel0), .ramping(ramp0));

  pwm_multi_ramp #(.CH(1), .CNT_W(6), .PERIOD(60), .PRESC(2), .STEP(7)) dut1 (
    .clkdiv4(clk), .reset(rst_n), .kbd(kbd), .center(center),
    .pwm(pwm1), .sel(sel1), .ramping(ramp1));

  always #5 clk = ~clk;

  // model parameters per instance
  int p_ch  [2] = '{4, 1};
  int p_per [2] = '{100, 60};
  int p_pre [2] = '{1, 2};
  int p_stp [2] = '{10, 7};

  // model state
  int m_pre [2];
  int m_cnt [2];
  int m_sel [2];
  int m_st  [2];   // 0 normal, 1 after break, 2 after extended
  int m_mode[2];
  int m_act [2][4];
  int m_tgt [2][4];

  logic [6:0] q0[$];
  logic [6:0] q1[$];

  int vectors = 0;
  int errors  = 0;

  function automatic int lvl_of(input logic [7:0] b);
    case (b)
      8'h2B:   return 41;
      8'h15:   return 51;
      8'h33:   return 61;
      8'h22:   return 81;
      8'h45:   return 0;
      default: return -1;
    endcase
  endfunction

  function automatic int chan_of(input logic [7:0] b);
    case (b)
      8'h16:   return 0;
      8'h1E:   return 1;
      8'h26:   return 2;
      8'h25:   return 3;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_pre[u] = 0; m_cnt[u] = 0; m_sel[u] = 0; m_st[u] = 0; m_mode[u] = 0;
      for (int i = 0; i < 4; i++) begin
        m_act[u][i] = 0;
        m_tgt[u][i] = 0;
      end
    end
  endtask

  // One clock of instance u; returns expected {pwm, sel, ramping} after the edge.
  task automatic model_step(input int u, input logic cv, input logic [7:0] sc,
                            input logic cen, output logic [6:0] e);
    logic [3:0] ep;
    logic r, bnd;
    int lo, lv, ch, d;
    ep = 4'd0;
    r  = 1'b0;
    for (int i = 0; i < p_ch[u]; i++) begin
      lo = (p_per[u] - m_act[u][i]) / 2;
      if (m_mode[u] != 0) ep[i] = (m_cnt[u] >= lo) && (m_cnt[u] < lo + m_act[u][i]);
      else ep[i] = (m_cnt[u] < m_act[u][i]);
      if (m_act[u][i] != m_tgt[u][i]) r = 1'b1;
    end
    bnd = (m_pre[u] == p_pre[u] - 1) && (m_cnt[u] == p_per[u] - 1);
    if (m_pre[u] == p_pre[u] - 1) begin
      m_pre[u] = 0;
      m_cnt[u] = (m_cnt[u] + 1) % p_per[u];
    end else begin
      m_pre[u] = m_pre[u] + 1;
    end
    if (bnd) begin
      for (int i = 0; i < p_ch[u]; i++) begin
        if (m_act[u][i] < m_tgt[u][i]) begin
          d = m_tgt[u][i] - m_act[u][i];
          m_act[u][i] += (d < p_stp[u]) ? d : p_stp[u];
        end else if (m_act[u][i] > m_tgt[u][i]) begin
          d = m_act[u][i] - m_tgt[u][i];
          m_act[u][i] -= (d < p_stp[u]) ? d : p_stp[u];
        end
      end
      m_mode[u] = cen ? 1 : 0;
    end
    if (cv) begin
      if (m_st[u] == 1) begin
        m_st[u] = 0;
      end else if (m_st[u] == 2) begin
        m_st[u] = (sc == 8'hF0) ? 1 : 0;
      end else if (sc == 8'hF0) begin
        m_st[u] = 1;
      end else if (sc == 8'hE0) begin
        m_st[u] = 2;
      end else begin
        ch = chan_of(sc);
        lv = lvl_of(sc);
        if (ch >= 0 && ch < p_ch[u]) m_sel[u] = ch;
        if (lv >= 0) m_tgt[u][m_sel[u]] = (lv > p_per[u]) ? p_per[u] : lv;
      end
    end
    e = {ep, 2'(m_sel[u]), r};
  endtask

  task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: pwm/sel/ramping got %b_%b_%b required %b_%b_%b", name, $time,
               got[6:3], got[2:1], got[0], exp[6:3], exp[2:1], exp[0]);
    end
  endtask

  // Reference model: advances on every clock, cleared by reset.
  initial begin
    logic [6:0] e;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
        q0.delete();
        q1.delete();
      end else begin
        model_step(0, kbd.code_valid, kbd.scancode, center, e);
        q0.push_back(e);
        model_step(1, kbd.code_valid, kbd.scancode, center, e);
        q1.push_back(e);
      end
    end
  end

  // Monitor: compare DUT outputs against queued expectations away from the edge.
  initial begin
    logic [6:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst0", {pwm0, sel0, ramp0}, 7'd0);
        check("rst1", {3'd0, pwm1, sel1, ramp1}, 7'd0);
      end else begin
        if (q0.size() > 0) begin
          e = q0.pop_front();
          check("dut0", {pwm0, sel0, ramp0}, e);
        end
        if (q1.size() > 0) begin
          e = q1.pop_front();
          check("dut1", {3'd0, pwm1, sel1, ramp1}, e);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    kbd.scancode   = b;
    kbd.code_valid = 1'b1;
    @(negedge clk);
    kbd.code_valid = 1'b0;
  endtask

  task automatic send2(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    kbd.scancode   = a;
    kbd.code_valid = 1'b1;
    @(negedge clk);
    kbd.scancode   = b;
    @(negedge clk);
    kbd.code_valid = 1'b0;
  endtask

  // Asynchronous reset in the middle of a clock, with an immediate output check.
  task automatic mid_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst0", {pwm0, sel0, ramp0}, 7'd0);
    check("async_rst1", {3'd0, pwm1, sel1, ramp1}, 7'd0);
    idle(3);
    rst_n = 1'b1;
  endtask

  logic [7:0] pool [16] = '{8'hF0, 8'hE0, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2B, 8'h15,
                            8'h33, 8'h22, 8'h45, 8'h1C, 8'h00, 8'hFF, 8'h29, 8'h45};

  function automatic logic [7:0] pick();
    logic [7:0] b;
    if ($urandom_range(0, 7) == 0) b = 8'($urandom);
    else b = pool[$urandom_range(0, 15)];
    return b;
  endfunction

  // Stimulus: directed scenarios, then randomized key traffic.
  initial begin
    kbd.scancode   = 8'h00;
    kbd.code_valid = 1'b0;
    #1 rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(10);

    send(8'h2B);                 // target0 = 41, ramp 10..41; dut1 clamps nothing
    idle(700);
    send(8'hF0); send(8'h2B);    // break swallows the level key
    idle(40);
    send(8'hE0); send(8'hF0); send(8'h2B);
    idle(40);
    send2(8'h1E, 8'h22);         // back-to-back: sel=1 then target1=81 (dut1: target0=60)
    idle(1000);
    @(negedge clk) center = 1'b1;
    idle(137);
    @(negedge clk) center = 1'b0; // mid-period toggle
    idle(63);
    @(negedge clk) center = 1'b1;
    idle(300);
    send(8'h16); send(8'h45);    // ramp channel 0 down to 0
    idle(600);
    send(8'h2B);
    idle(330);
    mid_reset();
    idle(50);

    for (int k = 0; k < 120; k++) begin
      if ($urandom_range(0, 3) == 0) send2(pick(), pick());
      else send(pick());
      if ($urandom_range(0, 7) == 0) center = ~center;
      if (k == 70) mid_reset();
      idle($urandom_range(0, 200));
    end
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
